sipo_rx: RTL and testbench

SIPO_RX -- requirements
Module: sipo_rx

---
 rtl/sipo_rx.sv | 124 ++++++++++++
 tb/tb_sipo_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: MSB-first framing on serial_first, one-word output buffer with ready/valid.
// Define SIPO_PARITY_EN to expect one even-parity bit after each word's data bits.
module sipo_rx #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             serial_first,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             sync_err,
    output logic             parity_err
);

`ifdef SIPO_PARITY_EN
    localparam int SR_W = WIDTH;
`else
    localparam int SR_W = WIDTH - 1;
`endif
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
`ifdef SIPO_PARITY_EN
        PARITY = 2'd2,
`endif
        SHIFT  = 2'd1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [SR_W-1:0]  shift_q;
    logic             complete;
    logic [WIDTH-1:0] word_d;
`ifdef SIPO_PARITY_EN
    logic             perr_d;
`endif

    always_comb begin
`ifdef SIPO_PARITY_EN
        word_d   = shift_q;
        perr_d   = ^{shift_q, serial_in};
        complete = serial_valid && !serial_first && (state == PARITY);
`else
        // The completing bit is merged directly so the word lands with zero added latency.
        word_d   = {shift_q, serial_in};
        complete = serial_valid && !serial_first && (state == SHIFT) && (count == LAST);
`endif
    end

`ifndef SIPO_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HUNT;
            count        <= '0;
            shift_q      <= '0;
            parallel_out <= '0;
            out_valid    <= 1'b0;
            overflow     <= 1'b0;
            sync_err     <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            overflow <= 1'b0;
            sync_err <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            // A completed word may only replace the buffer if it is empty or leaving this edge.
            if (complete) begin
                if (out_valid && !out_ready) begin
                    overflow <= 1'b1;
                end else begin
                    parallel_out <= word_d;
                    out_valid    <= 1'b1;
`ifdef SIPO_PARITY_EN
                    parity_err   <= perr_d;
`endif
                end
            end
            if (serial_valid) begin
                if (serial_first) begin
                    sync_err <= (state != HUNT);
                    shift_q  <= SR_W'(serial_in);
                    count    <= CNT_W'(1);
                    state    <= SHIFT;
                end else begin
                    case (state)
                        SHIFT: begin
                            shift_q <= SR_W'({shift_q, serial_in});
                            if (count == LAST) begin
`ifdef SIPO_PARITY_EN
                                count <= count + 1'b1;
                                state <= PARITY;
`else
                                count <= '0;
                                state <= HUNT;
`endif
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
`ifdef SIPO_PARITY_EN
                        PARITY: begin
                            count <= '0;
                            state <= HUNT;
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// Testbench for sipo_rx (WIDTH=3): vector table plus framing/overflow/reset corner sequences.
module tb_sipo_rx;
    localparam int W = 3;
`ifdef SIPO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         serial_in = 1'b0;
    logic         serial_valid = 1'b0;
    logic         serial_first = 1'b0;
    logic [W-1:0] parallel_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         overflow;
    logic         sync_err;
    logic         parity_err;

    sipo_rx #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
        .serial_first(serial_first), .parallel_out(parallel_out), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow), .sync_err(sync_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {logic [W-1:0] w; logic perr;} exp_t;
    typedef struct {logic [W-1:0] data; logic flip; logic [W-1:0] exp_w; logic exp_perr;} vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vecs[7];
    int n_cmp = 0, n_fail = 0;
    int sync_cnt = 0, ovf_cnt = 0, deliv_cnt = 0;
    int s0, o0, d0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every handshake pops one expected word.
    always @(negedge clk) begin
        if (!reset) begin
            if (sync_err) sync_cnt++;
            if (overflow) ovf_cnt++;
            if (out_valid && out_ready) begin
                deliv_cnt++;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h expected none", parallel_out);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("deliver_word", 32'(parallel_out), 32'(mon_e.w));
                    chk("deliver_perr", 32'(parity_err), 32'(mon_e.perr));
                end
            end
        end
    end

    task automatic send_bit(input logic b, input logic f);
        serial_in    = b;
        serial_first = f;
        serial_valid = 1'b1;
        @(posedge clk); #1;
        serial_valid = 1'b0;
        serial_first = 1'b0;
        serial_in    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic flip, input logic ready_last);
        send_bit(w[2], 1'b1);
        send_bit(w[1], 1'b0);
`ifdef SIPO_PARITY_EN
        send_bit(w[0], 1'b0);
        if (ready_last) out_ready = 1'b1;
        send_bit((^w) ^ flip, 1'b0);
`else
        if (ready_last) out_ready = 1'b1;
        send_bit(w[0], 1'b0);
`endif
    endtask

    initial begin
        vecs[0] = '{3'b000, 1'b0, 3'b000, 1'b0};
        vecs[1] = '{3'b111, 1'b1, 3'b111, PAR_EN};
        vecs[2] = '{3'b010, 1'b0, 3'b010, 1'b0};
        vecs[3] = '{3'b110, 1'b1, 3'b110, PAR_EN};
        vecs[4] = '{3'b011, 1'b0, 3'b011, 1'b0};
        vecs[5] = '{3'b001, 1'b1, 3'b001, PAR_EN};
        vecs[6] = '{3'b101, 1'b1, 3'b101, PAR_EN};

        // Reset with random inputs
        reset = 1'b1;
        repeat (2) begin
            serial_in = 1'($urandom); serial_valid = 1'($urandom);
            serial_first = 1'($urandom); out_ready = 1'($urandom);
            @(posedge clk); #1;
        end
        chk("rst_parallel_out", 32'(parallel_out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        serial_in = 1'b0; serial_valid = 1'b0; serial_first = 1'b0; out_ready = 1'b1;
        reset = 1'b0;
        idle(1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // HUNT ignores bits without first
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        idle(1);
        chk("hunt_no_output", 32'(out_valid), 32'd0);
        chk("hunt_no_sync", 32'(sync_cnt), 32'd0);

        // Basic word 101, one-cycle valid
        sbq.push_back('{3'b101, 1'b0});
        send_word(3'b101, 1'b0, 1'b0);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_word", 32'(parallel_out), 32'(3'b101));
        idle(1);
        chk("basic_valid_drop", 32'(out_valid), 32'd0);

        // Table-driven back-to-back words
        for (int i = 0; i < 7; i++) begin
            sbq.push_back('{vecs[i].exp_w, vecs[i].exp_perr});
            send_word(vecs[i].data, vecs[i].flip, 1'b0);
        end
        idle(2);
        chk("table_drained", 32'(sbq.size()), 32'd0);
        chk("table_no_sync", 32'(sync_cnt), 32'd0);
        chk("table_no_ovf", 32'(ovf_cnt), 32'd0);

        // Overflow: 100 held, 001 dropped
        out_ready = 1'b0;
        d0 = deliv_cnt;
        sbq.push_back('{3'b100, 1'b0});
        send_word(3'b100, 1'b0, 1'b0);
        idle(1);
        send_word(3'b001, 1'b1, 1'b0);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_hold_word", 32'(parallel_out), 32'(3'b100));
        chk("ovf_hold_valid", 32'(out_valid), 32'd1);
        chk("ovf_hold_perr", 32'(parity_err), 32'd0);
        idle(1);
        chk("ovf_pulse_end", 32'(overflow), 32'd0);
        chk("ovf_count", 32'(ovf_cnt), 32'd1);
        out_ready = 1'b1;
        idle(1);
        chk("ovf_drain_valid", 32'(out_valid), 32'd0);
        idle(2);
        chk("ovf_one_delivery", 32'(deliv_cnt - d0), 32'd1);
        chk("ovf_drained", 32'(sbq.size()), 32'd0);

        // Realignment: first+1, 1, then first+0, 0, 1
        s0 = sync_cnt;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        sbq.push_back('{3'b001, 1'b0});
        send_bit(1'b0, 1'b1);
        chk("sync_pulse", 32'(sync_err), 32'd1);
        send_bit(1'b0, 1'b0);
        chk("sync_pulse_end", 32'(sync_err), 32'd0);
        send_bit(1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
        send_bit(1'b1, 1'b0);
`endif
        idle(2);
        chk("sync_once", 32'(sync_cnt - s0), 32'd1);
        chk("sync_drained", 32'(sbq.size()), 32'd0);

        // Reset mid-word loses the partial word silently
        s0 = sync_cnt; o0 = ovf_cnt;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        reset = 1'b1;
        idle(1);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        sbq.push_back('{3'b110, 1'b0});
        send_word(3'b110, 1'b0, 1'b0);
        idle(2);
        chk("midrst_no_sync", 32'(sync_cnt - s0), 32'd0);
        chk("midrst_no_ovf", 32'(ovf_cnt - o0), 32'd0);
        chk("midrst_drained", 32'(sbq.size()), 32'd0);

        // Stalled word with serial_valid gaps
        sbq.push_back('{3'b011, 1'b0});
        send_bit(1'b0, 1'b1); idle(3);
        send_bit(1'b1, 1'b0); idle(1);
        send_bit(1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
        idle(2);
        send_bit(1'b0, 1'b0);
`endif
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_word", 32'(parallel_out), 32'(3'b011));
        idle(2);
        chk("stall_drained", 32'(sbq.size()), 32'd0);

        // Completion on the same edge as a handshake keeps valid high
        out_ready = 1'b0;
        o0 = ovf_cnt;
        sbq.push_back('{3'b010, 1'b0});
        send_word(3'b010, 1'b0, 1'b0);
        sbq.push_back('{3'b101, 1'b0});
        send_word(3'b101, 1'b0, 1'b1);
        chk("swap_valid", 32'(out_valid), 32'd1);
        chk("swap_word", 32'(parallel_out), 32'(3'b101));
        idle(2);
        chk("swap_no_ovf", 32'(ovf_cnt - o0), 32'd0);
        chk("swap_drained", 32'(sbq.size()), 32'd0);

`ifdef SIPO_PARITY_EN
        // first during the parity slot aborts the word
        s0 = sync_cnt;
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        chk("par_abort_sync", 32'(sync_err), 32'd1);
        sbq.push_back('{3'b011, 1'b1});
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        idle(2);
        chk("par_abort_once", 32'(sync_cnt - s0), 32'd1);
        chk("par_abort_drained", 32'(sbq.size()), 32'd0);
`endif

        idle(2);
        chk("final_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
